// File: rtl/aap_fetch_stage.sv
// Instruction fetch stage: a rate divider paces single-word fetches from
// instruction memory. One instruction is in flight at a time; it is held
// for the decoder until accepted, and redirect or reset abandons it.
//
// state | meaning
// IDLE  | waiting for a divider tick (live or pending)
// REQ   | read strobe out for one clock at address pc
// WAIT  | memory data returns this clock; capture it and advance pc
// HOLD  | instruction presented to decoder until handshake
module aap_fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DIV_MAX  = 217
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] fetchoutput,
  output logic [15:0] fetch_pc,
  output logic        fetch_valid,
  input  logic        dec_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  localparam logic [9:0] DIV_TC = DIV_MAX[9:0];

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state;
  state_t      state_next;
  logic [9:0]  div_cnt;
  logic        tick;
  logic        tick_pending;
  logic        enter_req;
  logic [15:0] pc;

  assign tick      = (div_cnt == DIV_TC);
  assign imem_addr = pc;
  assign enter_req = (state == IDLE) && (state_next == REQ);

  // Free-running fetch-rate divider, wraps at DIV_TC.
  always_ff @(posedge CLOCK_50) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 10'd1;
  end

  // Remember ticks that arrive while busy; the tick that starts a fetch is consumed.
  always_ff @(posedge CLOCK_50) begin
    if (reset)          tick_pending <= 1'b0;
    else if (enter_req) tick_pending <= 1'b0;
    else if (tick)      tick_pending <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and read strobe; redirect overrides everything, including a handshake.
  always_comb begin
    state_next = state;
    imem_rd    = 1'b0;
    case (state)
      IDLE: if (tick || tick_pending) state_next = REQ;
      REQ: begin
        imem_rd    = 1'b1;
        state_next = WAIT;
      end
      WAIT: state_next = HOLD;
      HOLD: if (fetch_valid && dec_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (redirect) state_next = IDLE;
  end

  // PC and decoder-facing registers; read data is dropped if redirect hits in WAIT.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      fetchoutput <= '0;
      fetch_pc    <= '0;
    end else if (redirect) begin
      pc          <= redirect_pc;
      fetch_valid <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          fetchoutput <= imem_rdata;
          fetch_pc    <= pc;
          fetch_valid <= 1'b1;
          pc          <= pc + 16'd1;
        end
        HOLD: if (fetch_valid && dec_ready) fetch_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aap_fetch_stage.sv
// Directed bench for aap_fetch_stage with DIV_MAX=3 (tick every 4 clocks).
// Cycle 0 is the first clock after reset is released; the divider reads 0
// there, so ticks fall on cycles 3, 7, 11, ...
module tb_aap_fetch_stage;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        imem_rd, imem_rd1;
  logic [15:0] imem_addr, imem_addr1;
  logic [15:0] imem_rdata, imem_rdata1;
  logic [15:0] fetchoutput, fetchoutput1;
  logic [15:0] fetch_pc, fetch_pc1;
  logic        fetch_valid, fetch_valid1;
  logic        dec_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        dec_ready1   = 1'b1;
  logic        redirect1    = 1'b0;
  logic [15:0] redirect_pc1 = 16'h0000;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  aap_fetch_stage #(.RESET_PC(16'h0000), .DIV_MAX(3)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .fetchoutput(fetchoutput), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
    .dec_ready(dec_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  aap_fetch_stage #(.RESET_PC(16'hFFFF), .DIV_MAX(3)) dut1 (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .imem_rd(imem_rd1), .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
    .fetchoutput(fetchoutput1), .fetch_pc(fetch_pc1), .fetch_valid(fetch_valid1),
    .dec_ready(dec_ready1), .redirect(redirect1), .redirect_pc(redirect_pc1)
  );

  function automatic logic [15:0] mem(input logic [15:0] a);
    return (a == 16'h0000) ? 16'h1234 : (a ^ 16'hA5A5);
  endfunction

  // One-clock-latency instruction memories.
  always @(posedge CLOCK_50) begin
    if (imem_rd)  imem_rdata  <= mem(imem_addr);
    if (imem_rd1) imem_rdata1 <= mem(imem_addr1);
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  logic [15:0] held_data, held_pc;

  initial begin
    reset       = 1'b1;
    dec_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_valid", {15'd0, fetch_valid}, 16'd0);
    chk("rst_rd",    {15'd0, imem_rd},     16'd0);
    chk("rst_addr",  imem_addr,            16'h0000);
    chk("rst_addr1", imem_addr1,           16'hFFFF);
    chk("rst_data",  fetchoutput,          16'h0000);
    chk("rst_pc",    fetch_pc,             16'h0000);
    reset = 1'b0;
    cyc   = 0;

    // First fetch: strobe on cycle 4, valid on cycle 6 for one clock.
    goto(3);
    chk("c3_rd", {15'd0, imem_rd}, 16'd0);
    goto(4);
    chk("c4_rd",   {15'd0, imem_rd}, 16'd1);
    chk("c4_addr", imem_addr,        16'h0000);
    goto(5);
    chk("c5_rd",    {15'd0, imem_rd},     16'd0);
    chk("c5_valid", {15'd0, fetch_valid}, 16'd0);
    goto(6);
    chk("c6_valid",  {15'd0, fetch_valid},  16'd1);
    chk("c6_data",   fetchoutput,           16'h1234);
    chk("c6_pc",     fetch_pc,              16'h0000);
    chk("c6_valid1", {15'd0, fetch_valid1}, 16'd1);
    chk("c6_pc1",    fetch_pc1,             16'hFFFF);
    chk("c6_data1",  fetchoutput1,          mem(16'hFFFF));
    goto(7);
    chk("c7_valid", {15'd0, fetch_valid}, 16'd0);
    dec_ready = 1'b0;

    // Second fetch from pc 1, held for 20 clocks with decoder stalled.
    goto(8);
    chk("c8_rd",   {15'd0, imem_rd}, 16'd1);
    chk("c8_addr", imem_addr,        16'h0001);
    goto(10);
    chk("c10_valid1", {15'd0, fetch_valid1}, 16'd1);
    chk("c10_pc1",    fetch_pc1,             16'h0000);
    held_data = mem(16'h0001);
    held_pc   = 16'h0001;
    for (int i = 0; i < 20; i++) begin
      chk("hold_valid", {15'd0, fetch_valid}, 16'd1);
      chk("hold_data",  fetchoutput,          held_data);
      chk("hold_pc",    fetch_pc,             held_pc);
      chk("hold_rd",    {15'd0, imem_rd},     16'd0);
      if (i == 19) dec_ready = 1'b1;
      step();
    end
    // cycle 30: handshake done; pending tick launches REQ next clock.
    chk("c30_valid", {15'd0, fetch_valid}, 16'd0);
    chk("c30_rd",    {15'd0, imem_rd},     16'd0);
    goto(31);
    chk("c31_rd",   {15'd0, imem_rd}, 16'd1);
    chk("c31_addr", imem_addr,        16'h0002);

    // Redirect during WAIT drops the in-flight word.
    goto(32);
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    goto(33);
    redirect = 1'b0;
    chk("c33_valid", {15'd0, fetch_valid}, 16'd0);
    chk("c33_addr",  imem_addr,            16'h0100);
    goto(34);
    chk("c34_rd",   {15'd0, imem_rd}, 16'd1);
    chk("c34_addr", imem_addr,        16'h0100);
    goto(35);
    chk("c35_valid", {15'd0, fetch_valid}, 16'd0);
    goto(36);
    chk("c36_valid", {15'd0, fetch_valid}, 16'd1);
    chk("c36_pc",    fetch_pc,             16'h0100);
    chk("c36_data",  fetchoutput,          mem(16'h0100));

    // Redirect wins over a simultaneous handshake in HOLD.
    redirect    = 1'b1;
    redirect_pc = 16'h0200;
    goto(37);
    redirect = 1'b0;
    chk("c37_valid", {15'd0, fetch_valid}, 16'd0);
    chk("c37_addr",  imem_addr,            16'h0200);
    goto(38);
    chk("c38_rd",   {15'd0, imem_rd}, 16'd1);
    chk("c38_addr", imem_addr,        16'h0200);
    goto(40);
    chk("c40_valid", {15'd0, fetch_valid}, 16'd1);
    chk("c40_pc",    fetch_pc,             16'h0200);
    chk("c40_data",  fetchoutput,          mem(16'h0200));
    goto(42);
    chk("c42_rd",   {15'd0, imem_rd}, 16'd1);
    chk("c42_addr", imem_addr,        16'h0201);

    // Reset for one clock in WAIT aborts the fetch.
    goto(43);
    reset = 1'b1;
    goto(44);
    reset = 1'b0;
    chk("r_valid", {15'd0, fetch_valid}, 16'd0);
    chk("r_rd",    {15'd0, imem_rd},     16'd0);
    chk("r_addr",  imem_addr,            16'h0000);
    chk("r_data",  fetchoutput,          16'h0000);
    chk("r_pc",    fetch_pc,             16'h0000);
    goto(46);
    chk("r46_valid", {15'd0, fetch_valid}, 16'd0);
    goto(47);
    chk("r47_rd", {15'd0, imem_rd}, 16'd0);
    goto(48);
    chk("r48_rd",   {15'd0, imem_rd}, 16'd1);
    chk("r48_addr", imem_addr,        16'h0000);
    goto(50);
    chk("r50_valid", {15'd0, fetch_valid}, 16'd1);
    chk("r50_pc",    fetch_pc,             16'h0000);
    chk("r50_data",  fetchoutput,          16'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
